// File: rtl/npc_sim_ctrl.sv
// npc_sim_ctrl: simulation-harness controller for one or more NPC cores.
// It sequences the DUT reset as an idle gap followed by an assert window. It then watches each
// hart's io_sync/io_simEnd pair and latches the per-hart exit codes. The run ends when every
// enabled hart has finished, or when a RUN-phase cycle watchdog fires.
//
// Ports:
//   clock, reset   bench clock (rising edge) and asynchronous active-low controller reset
//   restart        rerun the full sequence; only acted on in DONE or TIMEOUT
//   hart_en        harts required for completion, captured when RUN is entered
//   io_sync        per-hart commit strobe from the DUT
//   io_simEnd      per-hart end-of-program flag from the DUT
//   exit_code      per-hart exit code; hart i is at [i*CODE_W +: CODE_W]
//   dut_reset      active-high reset to the DUT(s)
//   running        controller is in RUN
//   done           controller is in DONE
//   timed_out      controller is in TIMEOUT
//   pass           in DONE: every enabled hart latched a zero exit code
//   end_mask       harts that have ended in this run
//   codes          latched exit codes, packed the same way as exit_code
//   run_cycles     cycles spent in RUN; saturates, and freezes when RUN is left
module npc_sim_ctrl #(
  parameter int unsigned NUM_HARTS        = 1,
  parameter int unsigned PRE_RESET_CYCLES = 10,
  parameter int unsigned RESET_CYCLES     = 10,
  parameter int unsigned TIMEOUT_CYCLES   = 5000000,
  parameter int unsigned CNT_W            = 32,
  parameter int unsigned CODE_W           = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        restart,
  input  logic [NUM_HARTS-1:0]        hart_en,
  input  logic [NUM_HARTS-1:0]        io_sync,
  input  logic [NUM_HARTS-1:0]        io_simEnd,
  input  logic [NUM_HARTS*CODE_W-1:0] exit_code,
  output logic                        dut_reset,
  output logic                        running,
  output logic                        done,
  output logic                        timed_out,
  output logic                        pass,
  output logic [NUM_HARTS-1:0]        end_mask,
  output logic [NUM_HARTS*CODE_W-1:0] codes,
  output logic [CNT_W-1:0]            run_cycles
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StPre     = 3'd1;
  localparam logic [2:0] StRst     = 3'd2;
  localparam logic [2:0] StRun     = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;
  localparam logic [2:0] StTimeout = 3'd5;

  // A window length of zero skips that phase entirely.
  localparam logic [2:0] AfterPre   = (RESET_CYCLES != 0) ? StRst : StRun;
  localparam logic [2:0] FirstPhase = (PRE_RESET_CYCLES != 0) ? StPre : AfterPre;

  // Last-cycle compare values. These wrap when a window is 0, but that phase is then never entered.
  localparam logic [CNT_W-1:0] PreLast = CNT_W'(PRE_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] RstLast = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] RunLast = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic [2:0]                  state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [NUM_HARTS-1:0]        en_q, en_d;
  logic [NUM_HARTS-1:0]        end_mask_q, end_mask_d;
  logic [NUM_HARTS*CODE_W-1:0] codes_q, codes_d;
  logic [CNT_W-1:0]            run_cycles_q, run_cycles_d;
  logic                        dut_reset_q, dut_reset_d;
  logic                        running_q, running_d;
  logic                        done_q, done_d;
  logic                        timed_out_q, timed_out_d;
  logic                        pass_q, pass_d;

  logic [NUM_HARTS-1:0]        new_ends;
  logic                        all_ended;

  // A hart ends only on its first qualified strobe, so the first exit code wins.
  assign new_ends  = io_sync & io_simEnd & en_q & ~end_mask_q;
  assign all_ended = (((end_mask_q | new_ends) & en_q) == en_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    en_d         = en_q;
    end_mask_d   = end_mask_q;
    codes_d      = codes_q;
    run_cycles_d = run_cycles_q;

    case (state_q)
      StIdle: begin
        state_d = FirstPhase;
        cnt_d   = '0;
      end
      StPre: begin
        if (cnt_q == PreLast) begin
          state_d = AfterPre;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StRst: begin
        if (cnt_q == RstLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StRun: begin
        end_mask_d = end_mask_q | new_ends;
        for (int i = 0; i < NUM_HARTS; i++) begin
          if (new_ends[i]) codes_d[i*CODE_W +: CODE_W] = exit_code[i*CODE_W +: CODE_W];
        end
        if (run_cycles_q != '1) run_cycles_d = run_cycles_q + CntOne;
        // Completion takes priority over the watchdog when both occur in the same cycle.
        if (all_ended)                 state_d = StDone;
        else if (run_cycles_q == RunLast) state_d = StTimeout;
      end
      StDone, StTimeout: begin
        if (restart) begin
          state_d = FirstPhase;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Every entry into RUN starts a fresh run with a newly sampled hart set.
    if (state_d == StRun && state_q != StRun) begin
      en_d         = hart_en;
      end_mask_d   = '0;
      codes_d      = '0;
      run_cycles_d = '0;
    end

    dut_reset_d = (state_d == StRst);
    running_d   = (state_d == StRun);
    done_d      = (state_d == StDone);
    timed_out_d = (state_d == StTimeout);
    pass_d      = (state_d == StDone);
    for (int i = 0; i < NUM_HARTS; i++) begin
      if (en_d[i] && (codes_d[i*CODE_W +: CODE_W] != '0)) pass_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      en_q         <= '0;
      end_mask_q   <= '0;
      codes_q      <= '0;
      run_cycles_q <= '0;
      dut_reset_q  <= 1'b0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      timed_out_q  <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      en_q         <= en_d;
      end_mask_q   <= end_mask_d;
      codes_q      <= codes_d;
      run_cycles_q <= run_cycles_d;
      dut_reset_q  <= dut_reset_d;
      running_q    <= running_d;
      done_q       <= done_d;
      timed_out_q  <= timed_out_d;
      pass_q       <= pass_d;
    end
  end

  assign dut_reset  = dut_reset_q;
  assign running    = running_q;
  assign done       = done_q;
  assign timed_out  = timed_out_q;
  assign pass       = pass_q;
  assign end_mask   = end_mask_q;
  assign codes      = codes_q;
  assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_npc_sim_ctrl.sv
// Directed bench for npc_sim_ctrl, using three instances with different parameter sets:
//   a: defaults (1 hart); b: 1 hart, watchdog of 50 cycles; c: 4 harts, PRE skipped, watchdog of 20.
module tb_npc_sim_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Instance a
  logic        a_rst_n, a_restart, a_en, a_sync, a_end;
  logic [31:0] a_code;
  logic        a_dut_reset, a_running, a_done, a_to, a_pass, a_mask;
  logic [31:0] a_codes, a_cyc;

  npc_sim_ctrl u_a (
    .clock(clock), .reset(a_rst_n), .restart(a_restart), .hart_en(a_en),
    .io_sync(a_sync), .io_simEnd(a_end), .exit_code(a_code),
    .dut_reset(a_dut_reset), .running(a_running), .done(a_done), .timed_out(a_to),
    .pass(a_pass), .end_mask(a_mask), .codes(a_codes), .run_cycles(a_cyc)
  );

  // Instance b
  logic        b_rst_n, b_restart, b_en, b_sync, b_end;
  logic [31:0] b_code;
  logic        b_dut_reset, b_running, b_done, b_to, b_pass, b_mask;
  logic [31:0] b_codes, b_cyc;

  npc_sim_ctrl #(
    .NUM_HARTS(1), .PRE_RESET_CYCLES(3), .RESET_CYCLES(2), .TIMEOUT_CYCLES(50)
  ) u_b (
    .clock(clock), .reset(b_rst_n), .restart(b_restart), .hart_en(b_en),
    .io_sync(b_sync), .io_simEnd(b_end), .exit_code(b_code),
    .dut_reset(b_dut_reset), .running(b_running), .done(b_done), .timed_out(b_to),
    .pass(b_pass), .end_mask(b_mask), .codes(b_codes), .run_cycles(b_cyc)
  );

  // Instance c
  logic         c_rst_n, c_restart;
  logic [3:0]   c_en, c_sync, c_end;
  logic [127:0] c_code;
  logic         c_dut_reset, c_running, c_done, c_to, c_pass;
  logic [3:0]   c_mask;
  logic [127:0] c_codes;
  logic [31:0]  c_cyc;

  npc_sim_ctrl #(
    .NUM_HARTS(4), .PRE_RESET_CYCLES(0), .RESET_CYCLES(2), .TIMEOUT_CYCLES(20)
  ) u_c (
    .clock(clock), .reset(c_rst_n), .restart(c_restart), .hart_en(c_en),
    .io_sync(c_sync), .io_simEnd(c_end), .exit_code(c_code),
    .dut_reset(c_dut_reset), .running(c_running), .done(c_done), .timed_out(c_to),
    .pass(c_pass), .end_mask(c_mask), .codes(c_codes), .run_cycles(c_cyc)
  );

  task automatic test_reset();
    repeat (3) @(negedge clock);
    tests++; if (a_dut_reset !== 1'b0) begin fails++; $display("FAIL rst_dut_reset got %0b want 0", a_dut_reset); end
    tests++; if (a_running !== 1'b0) begin fails++; $display("FAIL rst_running got %0b want 0", a_running); end
    tests++; if (a_done !== 1'b0) begin fails++; $display("FAIL rst_done got %0b want 0", a_done); end
    tests++; if (a_to !== 1'b0) begin fails++; $display("FAIL rst_timed_out got %0b want 0", a_to); end
    tests++; if (a_pass !== 1'b0) begin fails++; $display("FAIL rst_pass got %0b want 0", a_pass); end
    tests++; if (a_mask !== 1'b0) begin fails++; $display("FAIL rst_end_mask got %0b want 0", a_mask); end
    tests++; if (a_codes !== 32'd0) begin fails++; $display("FAIL rst_codes got %0h want 0", a_codes); end
    tests++; if (a_cyc !== 32'd0) begin fails++; $display("FAIL rst_run_cycles got %0d want 0", a_cyc); end
  endtask

  task automatic test_basic();
    a_rst_n = 1'b1;
    // Expect 10 cycles of PRE with dut_reset low, then 10 cycles of RST with it high.
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      tests++;
      if (a_dut_reset !== (i >= 10)) begin
        fails++; $display("FAIL basic_window[%0d] dut_reset got %0b want %0b", i, a_dut_reset, (i >= 10));
      end
    end
    @(negedge clock);
    tests++; if (a_running !== 1'b1) begin fails++; $display("FAIL basic_running got %0b want 1", a_running); end
    tests++; if (a_dut_reset !== 1'b0) begin fails++; $display("FAIL basic_dut_reset_run got %0b want 0", a_dut_reset); end
    tests++; if (a_cyc !== 32'd0) begin fails++; $display("FAIL basic_cyc0 got %0d want 0", a_cyc); end
    repeat (100) @(negedge clock);
    tests++; if (a_cyc !== 32'd100) begin fails++; $display("FAIL basic_cyc100 got %0d want 100", a_cyc); end
    a_sync = 1'b1; a_end = 1'b1; a_code = 32'd0;
    @(negedge clock);
    a_sync = 1'b0; a_end = 1'b0;
    tests++; if (a_done !== 1'b1) begin fails++; $display("FAIL basic_done got %0b want 1", a_done); end
    tests++; if (a_pass !== 1'b1) begin fails++; $display("FAIL basic_pass got %0b want 1", a_pass); end
    tests++; if (a_cyc !== 32'd101) begin fails++; $display("FAIL basic_run_cycles got %0d want 101", a_cyc); end
    tests++; if (a_to !== 1'b0) begin fails++; $display("FAIL basic_timed_out got %0b want 0", a_to); end
    tests++; if (a_running !== 1'b0) begin fails++; $display("FAIL basic_running_off got %0b want 0", a_running); end
    tests++; if (a_mask !== 1'b1) begin fails++; $display("FAIL basic_end_mask got %0b want 1", a_mask); end
  endtask

  task automatic test_first_code_wins();
    int hi = 0;
    int n = 0;
    a_restart = 1'b1;
    @(negedge clock);
    a_restart = 1'b0;
    tests++; if (a_done !== 1'b0) begin fails++; $display("FAIL restart_done got %0b want 0", a_done); end
    tests++; if (a_pass !== 1'b0) begin fails++; $display("FAIL restart_pass got %0b want 0", a_pass); end
    while (!a_running && n < 40) begin
      if (a_dut_reset) hi++;
      @(negedge clock);
      n++;
    end
    tests++; if (a_running !== 1'b1) begin fails++; $display("FAIL restart_reach_run got %0b want 1", a_running); end
    tests++; if (hi != 10) begin fails++; $display("FAIL restart_rst_window got %0d want 10", hi); end
    tests++; if (n != 20) begin fails++; $display("FAIL restart_replay_len got %0d want 20", n); end
    tests++; if (a_mask !== 1'b0) begin fails++; $display("FAIL restart_end_mask got %0b want 0", a_mask); end
    tests++; if (a_cyc !== 32'd0) begin fails++; $display("FAIL restart_run_cycles got %0d want 0", a_cyc); end
    a_sync = 1'b0; a_end = 1'b1; a_code = 32'd5;
    @(negedge clock);
    tests++; if (a_mask !== 1'b0) begin fails++; $display("FAIL nosync_end_mask got %0b want 0", a_mask); end
    tests++; if (a_running !== 1'b1) begin fails++; $display("FAIL nosync_running got %0b want 1", a_running); end
    a_sync = 1'b1; a_code = 32'd7;
    @(negedge clock);
    tests++; if (a_done !== 1'b1) begin fails++; $display("FAIL code7_done got %0b want 1", a_done); end
    tests++; if (a_codes !== 32'd7) begin fails++; $display("FAIL code7_codes got %0d want 7", a_codes); end
    tests++; if (a_pass !== 1'b0) begin fails++; $display("FAIL code7_pass got %0b want 0", a_pass); end
    a_code = 32'd0;
    @(negedge clock);
    a_sync = 1'b0; a_end = 1'b0;
    tests++; if (a_codes !== 32'd7) begin fails++; $display("FAIL code_frozen got %0d want 7", a_codes); end
    tests++; if (a_done !== 1'b1) begin fails++; $display("FAIL done_sticky got %0b want 1", a_done); end
  endtask

  task automatic test_reset_midrun();
    int n = 0;
    a_restart = 1'b1;
    @(negedge clock);
    a_restart = 1'b0;
    while (!a_running && n < 40) begin @(negedge clock); n++; end
    tests++; if (a_running !== 1'b1) begin fails++; $display("FAIL midrun_reach_run got %0b want 1", a_running); end
    repeat (5) @(negedge clock);
    #2 a_rst_n = 1'b0;
    #1;
    tests++; if (a_running !== 1'b0) begin fails++; $display("FAIL midrun_running got %0b want 0", a_running); end
    tests++; if (a_cyc !== 32'd0) begin fails++; $display("FAIL midrun_run_cycles got %0d want 0", a_cyc); end
    tests++; if (a_dut_reset !== 1'b0) begin fails++; $display("FAIL midrun_dut_reset got %0b want 0", a_dut_reset); end
    tests++; if (a_codes !== 32'd0) begin fails++; $display("FAIL midrun_codes got %0h want 0", a_codes); end
    @(negedge clock);
    tests++; if (a_running !== 1'b0) begin fails++; $display("FAIL midrun_held got %0b want 0", a_running); end
  endtask

  task automatic test_timeout();
    int n = 0;
    b_rst_n = 1'b1;
    while (!b_running && n < 20) begin @(negedge clock); n++; end
    tests++; if (b_running !== 1'b1) begin fails++; $display("FAIL to_reach_run got %0b want 1", b_running); end
    tests++; if (b_cyc !== 32'd0) begin fails++; $display("FAIL to_cyc0 got %0d want 0", b_cyc); end
    repeat (10) @(negedge clock);
    b_restart = 1'b1;
    @(negedge clock);
    b_restart = 1'b0;
    tests++; if (b_running !== 1'b1) begin fails++; $display("FAIL to_restart_ignored got %0b want 1", b_running); end
    tests++; if (b_cyc !== 32'd11) begin fails++; $display("FAIL to_cyc11 got %0d want 11", b_cyc); end
    repeat (38) @(negedge clock);
    tests++; if (b_running !== 1'b1) begin fails++; $display("FAIL to_cyc49_running got %0b want 1", b_running); end
    tests++; if (b_to !== 1'b0) begin fails++; $display("FAIL to_early got %0b want 0", b_to); end
    @(negedge clock);
    tests++; if (b_to !== 1'b1) begin fails++; $display("FAIL to_fired got %0b want 1", b_to); end
    tests++; if (b_running !== 1'b0) begin fails++; $display("FAIL to_running got %0b want 0", b_running); end
    tests++; if (b_cyc !== 32'd50) begin fails++; $display("FAIL to_run_cycles got %0d want 50", b_cyc); end
    tests++; if (b_mask !== 1'b0) begin fails++; $display("FAIL to_end_mask got %0b want 0", b_mask); end
    tests++; if (b_pass !== 1'b0) begin fails++; $display("FAIL to_pass got %0b want 0", b_pass); end
    tests++; if (b_done !== 1'b0) begin fails++; $display("FAIL to_done got %0b want 0", b_done); end
    repeat (3) @(negedge clock);
    tests++; if (b_to !== 1'b1) begin fails++; $display("FAIL to_sticky got %0b want 1", b_to); end
    tests++; if (b_cyc !== 32'd50) begin fails++; $display("FAIL to_frozen got %0d want 50", b_cyc); end
  endtask

  task automatic test_multi_hart();
    int n = 0;
    c_en = 4'b1011;
    c_rst_n = 1'b1;
    @(negedge clock);
    tests++; if (c_dut_reset !== 1'b1) begin fails++; $display("FAIL mh_pre_skipped got %0b want 1", c_dut_reset); end
    while (!c_running && n < 10) begin @(negedge clock); n++; end
    tests++; if (c_running !== 1'b1) begin fails++; $display("FAIL mh_reach_run got %0b want 1", c_running); end
    tests++; if (n != 2) begin fails++; $display("FAIL mh_rst_len got %0d want 2", n); end
    // Harts 0 and 1 end with code 0; hart 2 is disabled and must be ignored.
    c_sync = 4'b0111; c_end = 4'b0111; c_code = {32'd0, 32'd9, 32'd0, 32'd0};
    @(negedge clock);
    tests++; if (c_mask !== 4'b0011) begin fails++; $display("FAIL mh_mask01 got %b want 0011", c_mask); end
    tests++; if (c_running !== 1'b1) begin fails++; $display("FAIL mh_still_running got %0b want 1", c_running); end
    // A second strobe from hart 1 must not overwrite its code.
    c_sync = 4'b0010; c_end = 4'b0010; c_code = {32'd0, 32'd0, 32'd5, 32'd0};
    @(negedge clock);
    tests++; if (c_codes[63:32] !== 32'd0) begin fails++; $display("FAIL mh_h1_first_wins got %0d want 0", c_codes[63:32]); end
    c_sync = 4'b1000; c_end = 4'b1000; c_code = {32'd3, 32'd0, 32'd0, 32'd0};
    @(negedge clock);
    c_sync = 4'b0000; c_end = 4'b0000;
    tests++; if (c_done !== 1'b1) begin fails++; $display("FAIL mh_done got %0b want 1", c_done); end
    tests++; if (c_pass !== 1'b0) begin fails++; $display("FAIL mh_pass got %0b want 0", c_pass); end
    tests++; if (c_mask !== 4'b1011) begin fails++; $display("FAIL mh_mask got %b want 1011", c_mask); end
    tests++; if (c_codes[127:96] !== 32'd3) begin fails++; $display("FAIL mh_code3 got %0d want 3", c_codes[127:96]); end
    tests++; if (c_codes[95:64] !== 32'd0) begin fails++; $display("FAIL mh_code2 got %0d want 0", c_codes[95:64]); end
  endtask

  task automatic test_watchdog_tie();
    int n = 0;
    c_en = 4'b0001;
    c_restart = 1'b1;
    @(negedge clock);
    c_restart = 1'b0;
    while (!c_running && n < 10) begin @(negedge clock); n++; end
    tests++; if (c_running !== 1'b1) begin fails++; $display("FAIL tie_reach_run got %0b want 1", c_running); end
    repeat (19) @(negedge clock);
    tests++; if (c_cyc !== 32'd19) begin fails++; $display("FAIL tie_cyc19 got %0d want 19", c_cyc); end
    c_sync = 4'b0001; c_end = 4'b0001; c_code = '0;
    @(negedge clock);
    c_sync = 4'b0000; c_end = 4'b0000;
    tests++; if (c_done !== 1'b1) begin fails++; $display("FAIL tie_done got %0b want 1", c_done); end
    tests++; if (c_to !== 1'b0) begin fails++; $display("FAIL tie_timed_out got %0b want 0", c_to); end
    tests++; if (c_pass !== 1'b1) begin fails++; $display("FAIL tie_pass got %0b want 1", c_pass); end
    tests++; if (c_cyc !== 32'd20) begin fails++; $display("FAIL tie_run_cycles got %0d want 20", c_cyc); end
  endtask

  task automatic test_no_harts();
    int n = 0;
    c_en = 4'b0000;
    c_restart = 1'b1;
    @(negedge clock);
    c_restart = 1'b0;
    while (!c_running && n < 10) begin @(negedge clock); n++; end
    tests++; if (c_running !== 1'b1) begin fails++; $display("FAIL nh_reach_run got %0b want 1", c_running); end
    tests++; if (c_mask !== 4'b0000) begin fails++; $display("FAIL nh_mask_cleared got %b want 0000", c_mask); end
    @(negedge clock);
    tests++; if (c_done !== 1'b1) begin fails++; $display("FAIL nh_done got %0b want 1", c_done); end
    tests++; if (c_pass !== 1'b1) begin fails++; $display("FAIL nh_pass got %0b want 1", c_pass); end
    tests++; if (c_cyc !== 32'd1) begin fails++; $display("FAIL nh_run_cycles got %0d want 1", c_cyc); end
  endtask

  initial begin
    a_rst_n = 1'b0; a_restart = 1'b0; a_en = 1'b1; a_sync = 1'b0; a_end = 1'b0; a_code = '0;
    b_rst_n = 1'b0; b_restart = 1'b0; b_en = 1'b1; b_sync = 1'b0; b_end = 1'b0; b_code = '0;
    c_rst_n = 1'b0; c_restart = 1'b0; c_en = '0; c_sync = '0; c_end = '0; c_code = '0;
    test_reset();
    test_basic();
    test_first_code_wins();
    test_reset_midrun();
    test_timeout();
    test_multi_hart();
    test_watchdog_tie();
    test_no_harts();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
